// File: rtl/riscv_dmem_arbiter.sv
// rtl/riscv_dmem_arbiter.sv - shares one synchronous data-memory port between the CPU and the UART programmer
module riscv_dmem_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int UPG_MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              upg_req,
    input  logic [ADDR_W-1:0] upg_addr,
    input  logic [DATA_W-1:0] upg_wdata,
    input  logic              upg_lock,
    output logic              upg_gnt,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam logic [3:0] MAX_RUN = 4'(UPG_MAX_RUN);

    state_t            state;
    state_t            state_n;
    logic [3:0]        run_cnt;
    logic [3:0]        run_cnt_n;
    logic [DATA_W-1:0] rdata_q;

    logic              upg_win;
    logic              en_c;
    logic [3:0]        we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic              gnt_c;
    logic              stall_c;
    logic              rvalid_c;
    logic              owner_c;
    logic [DATA_W-1:0] rdata_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            run_cnt <= 4'd0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            run_cnt <= run_cnt_n;
            if (state == CPU_RD) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_n   = state;
        run_cnt_n = run_cnt;
        upg_win   = 1'b0;
        en_c      = 1'b0;
        we_c      = 4'h0;
        addr_c    = '0;
        wdata_c   = '0;
        gnt_c     = 1'b0;
        stall_c   = 1'b0;
        rvalid_c  = 1'b0;
        owner_c   = 1'b0;
        rdata_c   = rdata_q;

        case (state)
            IDLE: begin
                // Programmer has priority, but only for MAX_RUN back-to-back wins over a waiting CPU
                upg_win = upg_req && (!cpu_req || (run_cnt < MAX_RUN));
                state_n = upg_lock ? LOCK : IDLE;
                if (upg_win) begin
                    en_c    = 1'b1;
                    we_c    = 4'hF;
                    addr_c  = upg_addr;
                    wdata_c = upg_wdata;
                    gnt_c   = 1'b1;
                    owner_c = 1'b1;
                    stall_c = cpu_req;
                    if (!cpu_req) begin
                        run_cnt_n = 4'd0;
                    end else if (run_cnt != 4'hF) begin
                        run_cnt_n = run_cnt + 4'd1;
                    end
                end else if (cpu_req) begin
                    en_c      = 1'b1;
                    addr_c    = cpu_addr;
                    wdata_c   = cpu_wdata;
                    run_cnt_n = 4'd0;
                    if (cpu_we) begin
                        we_c = cpu_be;
                    end else begin
                        // An issued load must return its data before a lock session starts
                        stall_c = 1'b1;
                        state_n = CPU_RD;
                    end
                end
            end
            CPU_RD: begin
                rvalid_c = 1'b1;
                rdata_c  = mem_rdata;
                state_n  = upg_lock ? LOCK : IDLE;
            end
            LOCK: begin
                gnt_c     = upg_req;
                stall_c   = cpu_req;
                run_cnt_n = 4'd0;
                state_n   = upg_lock ? LOCK : IDLE;
                if (upg_req) begin
                    en_c    = 1'b1;
                    we_c    = 4'hF;
                    addr_c  = upg_addr;
                    wdata_c = upg_wdata;
                    owner_c = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are forced quiet for as long as reset is held, not only after the reset edge
    assign mem_en     = rst & en_c;
    assign mem_we     = rst ? we_c : 4'h0;
    assign mem_addr   = rst ? addr_c : '0;
    assign mem_wdata  = rst ? wdata_c : '0;
    assign upg_gnt    = rst & gnt_c;
    assign cpu_stall  = rst & stall_c;
    assign cpu_rvalid = rst & rvalid_c;
    assign owner      = rst & owner_c;
    assign cpu_rdata  = rst ? rdata_c : '0;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb/tb_riscv_dmem_arbiter.sv - scoreboard bench for riscv_dmem_arbiter
module tb_riscv_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_stall;
    logic        upg_req;
    logic [13:0] upg_addr;
    logic [31:0] upg_wdata;
    logic        upg_lock;
    logic        upg_gnt;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        owner;

    riscv_dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .UPG_MAX_RUN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_be     (cpu_be),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_stall  (cpu_stall),
        .upg_req    (upg_req),
        .upg_addr   (upg_addr),
        .upg_wdata  (upg_wdata),
        .upg_lock   (upg_lock),
        .upg_gnt    (upg_gnt),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .owner      (owner)
    );

    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic        gnt;
        logic        stall;
        logic        rvalid;
        logic [31:0] rdata;
        logic        own;
    } out_t;

    typedef struct {
        string nm;
        out_t  v;
        out_t  m;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for the current cycle; address/data are don't-care when the port is idle
    task automatic chk(input string nm, input logic en, input logic [3:0] we, input logic [13:0] a,
                       input logic [31:0] wd, input logic gnt, input logic stall, input logic rv,
                       input logic [31:0] rd, input logic own);
        exp_t e;
        e.nm = nm;
        e.v  = '{en: en, we: we, addr: a, wdata: wd, gnt: gnt, stall: stall, rvalid: rv, rdata: rd, own: own};
        e.m  = '1;
        if (!en) begin
            e.m.addr  = '0;
            e.m.wdata = '0;
        end else if (we == 4'h0) begin
            e.m.wdata = '0;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            out_t act;
            e   = exp_q.pop_front();
            act = '{en: mem_en, we: mem_we, addr: mem_addr, wdata: mem_wdata, gnt: upg_gnt,
                    stall: cpu_stall, rvalid: cpu_rvalid, rdata: cpu_rdata, own: owner};
            checks++;
            if (((act ^ e.v) & e.m) != '0) begin
                errors++;
                $display("FAIL %s: got en=%b we=%h addr=%h wd=%h gnt=%b stall=%b rv=%b rd=%h own=%b, expected en=%b we=%h addr=%h wd=%h gnt=%b stall=%b rv=%b rd=%h own=%b",
                         e.nm, act.en, act.we, act.addr, act.wdata, act.gnt, act.stall, act.rvalid, act.rdata, act.own,
                         e.v.en, e.v.we, e.v.addr, e.v.wdata, e.v.gnt, e.v.stall, e.v.rvalid, e.v.rdata, e.v.own);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_be    = 4'h0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        upg_req   = 1'b0;
        upg_addr  = '0;
        upg_wdata = '0;
        upg_lock  = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Reset held: outputs quiet even with a request present
        nxt();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; upg_req = 1'b1;
        chk("reset_hold", 0, 4'h0, 0, 0, 0, 0, 0, 32'h0, 0);
        nxt();
        rst = 1'b1;
        idle_inputs();
        chk("reset_state", 0, 4'h0, 0, 0, 0, 0, 0, 32'h0, 0);

        nxt();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0011; cpu_addr = 14'h10; cpu_wdata = 32'hDEADBEEF;
        chk("cpu_store", 1, 4'b0011, 14'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0);
        nxt();
        cpu_be = 4'h0; cpu_addr = 14'h70; cpu_wdata = 32'h0BAD0BAD;
        chk("cpu_store_be0", 1, 4'h0, 14'h70, 32'h0, 0, 0, 0, 32'h0, 0);
        nxt();
        idle_inputs();
        upg_req = 1'b1; upg_addr = 14'h80; upg_wdata = 32'hA5A5A5A5;
        chk("upg_alone", 1, 4'hF, 14'h80, 32'hA5A5A5A5, 1, 0, 0, 32'h0, 1);

        nxt();
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h20;
        chk("load_issue", 1, 4'h0, 14'h20, 32'h0, 0, 1, 0, 32'h0, 0);
        nxt();
        mem_rdata = 32'h12345678;
        chk("load_rvalid", 0, 4'h0, 0, 0, 0, 0, 1, 32'h12345678, 0);
        nxt();
        cpu_req = 1'b0; mem_rdata = 32'hAAAAAAAA;
        chk("load_hold1", 0, 4'h0, 0, 0, 0, 0, 0, 32'h12345678, 0);
        nxt();
        chk("load_hold2", 0, 4'h0, 0, 0, 0, 0, 0, 32'h12345678, 0);

        // Fairness: both requesters held, four programmer wins then one CPU win
        nxt();
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 14'h30; cpu_wdata = 32'h11111111;
        upg_req = 1'b1; upg_addr = 14'h100; upg_wdata = 32'h22222222;
        for (int i = 0; i < 15; i++) begin
            if (i != 0) nxt();
            if ((i % 5) < 4)
                chk("fair_upg", 1, 4'hF, 14'h100, 32'h22222222, 1, 1, 0, 32'h12345678, 1);
            else
                chk("fair_cpu", 1, 4'hF, 14'h30, 32'h11111111, 0, 0, 0, 32'h12345678, 0);
        end

        // Lock session with the CPU waiting throughout
        nxt();
        upg_lock = 1'b1; upg_addr = 14'h200; upg_wdata = 32'h0;
        chk("lock_entry", 1, 4'hF, 14'h200, 32'h0, 1, 1, 0, 32'h12345678, 1);
        for (int i = 1; i < 7; i++) begin
            nxt();
            upg_addr = 14'h200 + 14'(i); upg_wdata = 32'(i);
            chk("lock_write", 1, 4'hF, 14'h200 + 14'(i), 32'(i), 1, 1, 0, 32'h12345678, 1);
        end
        nxt();
        upg_lock = 1'b0; upg_addr = 14'h207; upg_wdata = 32'h7;
        chk("lock_last", 1, 4'hF, 14'h207, 32'h7, 1, 1, 0, 32'h12345678, 1);
        nxt();
        upg_req = 1'b0;
        chk("lock_exit_cpu", 1, 4'hF, 14'h30, 32'h11111111, 0, 0, 0, 32'h12345678, 0);

        // Lock requested while a load is in flight
        nxt();
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 14'h40;
        chk("ld2_issue", 1, 4'h0, 14'h40, 32'h0, 0, 1, 0, 32'h12345678, 0);
        nxt();
        cpu_req = 1'b0; upg_lock = 1'b1; upg_req = 1'b1; upg_addr = 14'h300; upg_wdata = 32'h33;
        mem_rdata = 32'hCAFEF00D;
        chk("ld2_rvalid", 0, 4'h0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0);
        nxt();
        mem_rdata = 32'h0;
        chk("ld2_lock_gnt", 1, 4'hF, 14'h300, 32'h33, 1, 0, 0, 32'hCAFEF00D, 1);
        nxt();
        upg_lock = 1'b0; upg_addr = 14'h301; upg_wdata = 32'h34;
        chk("ld2_lock_last", 1, 4'hF, 14'h301, 32'h34, 1, 0, 0, 32'hCAFEF00D, 1);
        nxt();
        upg_req = 1'b0;
        chk("ld2_idle", 0, 4'h0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0);

        // Reset while the read data is returning
        nxt();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h50;
        chk("rst_ld_issue", 1, 4'h0, 14'h50, 32'h0, 0, 1, 0, 32'hCAFEF00D, 0);
        nxt();
        rst = 1'b0; mem_rdata = 32'h55555555;
        chk("rst_in_rd", 0, 4'h0, 0, 0, 0, 0, 0, 32'h0, 0);
        nxt();
        rst = 1'b1; cpu_req = 1'b0; mem_rdata = 32'h0;
        chk("rst_after", 0, 4'h0, 0, 0, 0, 0, 0, 32'h0, 0);
        nxt();
        cpu_req = 1'b1; cpu_addr = 14'h60;
        chk("rst_ld_fresh", 1, 4'h0, 14'h60, 32'h0, 0, 1, 0, 32'h0, 0);
        nxt();
        cpu_req = 1'b0; mem_rdata = 32'h89ABCDEF;
        chk("rst_ld_rvalid", 0, 4'h0, 0, 0, 0, 0, 1, 32'h89ABCDEF, 0);
        nxt();
        mem_rdata = 32'h0;
        chk("rst_ld_hold", 0, 4'h0, 0, 0, 0, 0, 0, 32'h89ABCDEF, 0);

        nxt();
        nxt();
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: queue depth %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
